// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor: one CW-bit chunk resolved per stage,
// carry registered between stages, single global advance enable for valid/ready flow.
module pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] augend,
  input  logic [WIDTH-1:0] addend,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_adder: WIDTH must be >= 2 and divisible by STAGES in 1..WIDTH");
  end

  logic adv;
  logic carry_q, carry_d;
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // IW: operand bits still unconsumed on entry; RW: result bits resolved on exit
    localparam int unsigned IW = WIDTH - k * CW;
    localparam int unsigned RW = (k + 1) * CW;

    logic          vin;
    logic [IW-1:0] op_a;
    logic [IW-1:0] op_b;
    logic          cin_k;
    logic          sub_k;
    logic [RW-1:0] res;
    logic [CW:0]   chunk;
    logic          v_q, v_d;
    logic [RW-1:0] r_q, r_d;

    if (k == 0) begin : g_head
      // Subtraction enters as A + ~B + ~borrow_in
      assign vin   = in_valid;
      assign op_a  = augend;
      assign op_b  = addend ^ {WIDTH{sub}};
      assign cin_k = cin ^ sub;
      assign sub_k = sub;
      assign res   = chunk[CW-1:0];
    end else begin : g_link
      assign vin   = g_st[k-1].v_q;
      assign op_a  = g_st[k-1].g_ops.a_q;
      assign op_b  = g_st[k-1].g_ops.b_q;
      assign cin_k = g_st[k-1].g_ops.c_q;
      assign sub_k = g_st[k-1].g_ops.s_q;
      assign res   = {chunk[CW-1:0], g_st[k-1].r_q};
    end

    assign chunk = {1'b0, op_a[CW-1:0]} + {1'b0, op_b[CW-1:0]} + {{CW{1'b0}}, cin_k};

    // Valid shifts on every advance; data only follows a valid slot
    always_comb begin
      v_d = v_q;
      r_d = r_q;
      if (adv) begin
        v_d = vin;
        if (vin) begin
          r_d = res;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        r_q <= '0;
      end else begin
        v_q <= v_d;
        r_q <= r_d;
      end
    end

    if (k < LAST) begin : g_ops
      localparam int unsigned OW = IW - CW;

      logic [OW-1:0] a_q, a_d;
      logic [OW-1:0] b_q, b_d;
      logic          c_q, c_d;
      logic          s_q, s_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        s_d = s_q;
        if (adv && vin) begin
          a_d = op_a[IW-1:CW];
          b_d = op_b[IW-1:CW];
          c_d = chunk[CW];
          s_d = sub_k;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          s_q <= 1'b0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
          c_q <= c_d;
          s_q <= s_d;
        end
      end
    end else begin : g_flags
      // MSB carry-in recovered as a ^ b ^ s at the top bit
      always_comb begin
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (adv && vin) begin
          carry_d = chunk[CW] ^ sub_k;
          ovf_d   = chunk[CW] ^ (op_a[CW-1] ^ op_b[CW-1] ^ chunk[CW-1]);
          zero_d  = ~|res;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
          zero_q  <= 1'b0;
        end else begin
          carry_q <= carry_d;
          ovf_q   <= ovf_d;
          zero_q  <= zero_d;
        end
      end
    end
  end

  assign adv       = !g_st[LAST].v_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = g_st[LAST].v_q;
  assign sum       = g_st[LAST].r_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed literal cases, random streams against an
// arithmetic reference queue, mid-flight reset and two corner configurations.
module tb_pipe_adder;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] augend = '0;
  logic [W-1:0] addend = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         zero;

  // shared stimulus for the two 8-bit corner configurations
  logic       c_valid = 1'b0;
  logic [7:0] c_a = '0;
  logic [7:0] c_b = '0;
  logic       c_cin = 1'b0;
  logic       c_sub = 1'b0;
  logic       c_ordy = 1'b1;
  logic       s1_ready, s1_valid, s1_carry, s1_ovf, s1_zero;
  logic [7:0] s1_sum;
  logic       s8_ready, s8_valid, s8_carry, s8_ovf, s8_zero;
  logic [7:0] s8_sum;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .augend(augend), .addend(addend), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry(carry), .overflow(overflow), .zero(zero)
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(s1_ready),
    .augend(c_a), .addend(c_b), .cin(c_cin), .sub(c_sub),
    .out_valid(s1_valid), .out_ready(c_ordy), .sum(s1_sum),
    .carry(s1_carry), .overflow(s1_ovf), .zero(s1_zero)
  );

  pipe_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(s8_ready),
    .augend(c_a), .addend(c_b), .cin(c_cin), .sub(c_sub),
    .out_valid(s8_valid), .out_ready(c_ordy), .sum(s8_sum),
    .carry(s8_carry), .overflow(s8_ovf), .zero(s8_zero)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: wide unsigned arithmetic for sum/carry, signed range test for overflow
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic s);
    exp_t    r;
    logic [W:0] full;
    longint  sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      sr   = sa + sb + longint'(ci);
    end else begin
      full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
      sr   = sa - sb - longint'(ci);
    end
    r.sum = full[W-1:0];
    r.c   = full[W];
    r.o   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z   = (full[W-1:0] == '0);
    return r;
  endfunction

  // Compare process: outputs and inputs are stable at the falling edge
  logic         hold = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_c, p_o, p_z;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold <= 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_sum", 64'(sum), 64'(p_sum));
        chk("stall_flags", {61'd0, carry, overflow, zero}, {61'd0, p_c, p_o, p_z});
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: out_valid=1 sum=0x%0h, expected no result pending at %0t", sum, $time);
        end else begin
          chk("model_sum", 64'(sum), 64'(exp_q[0].sum));
          chk("model_flags", {61'd0, carry, overflow, zero},
              {61'd0, exp_q[0].c, exp_q[0].o, exp_q[0].z});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(augend, addend, cin, sub));
      hold  <= out_valid && !out_ready;
      p_sum <= sum;
      p_c   <= carry;
      p_o   <= overflow;
      p_z   <= zero;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Single operation with out_ready=1; checks exact latency and literal result
  task automatic do_dir(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s, input logic [W-1:0] es,
                        input logic ec, input logic eo, input logic ez);
    in_valid  = 1'b1;
    augend    = a;
    addend    = b;
    cin       = ci;
    sub       = s;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    augend   = $urandom;
    addend   = $urandom;
    for (int i = 1; i <= int'(S); i++) begin
      @(negedge clk);
      chk({name, "_latency"}, 64'(out_valid), 64'(i == int'(S)));
    end
    chk({name, "_sum"}, 64'(sum), 64'(es));
    chk({name, "_carry"}, 64'(carry), 64'(ec));
    chk({name, "_ovf"}, 64'(overflow), 64'(eo));
    chk({name, "_zero"}, 64'(zero), 64'(ez));
    step();
  endtask

  task automatic rand_op();
    augend = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : W'($urandom);
    addend = ($urandom_range(7) == 0) ? 32'h8000_0000 : W'($urandom);
    cin    = 1'($urandom);
    sub    = 1'($urandom);
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [6:0] pat;
    int         acc;
    int         cyc;
    logic       took;

    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", {61'd0, carry, overflow, zero}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    do_dir("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    do_dir("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_dir("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    do_dir("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    do_dir("sub_bin", 32'd7, 32'd5, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);

    // 16 back-to-back operations, out_ready cycling 1,1,0,1,0,0,1
    pat = 7'b1001011;
    acc = 0;
    cyc = 0;
    in_valid = 1'b1;
    rand_op();
    while (acc < 16 && cyc < 200) begin
      out_ready = pat[cyc % 7];
      #1;
      took = in_ready;
      step();
      if (took) begin
        acc++;
        rand_op();
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_accepted", 64'(acc), 64'd16);
    drain("stream");

    // Random valid gaps and random backpressure
    for (int i = 0; i < 120; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      rand_op();
      step();
    end
    drain("random");

    // Reset with three operations in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_op();
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
    end
    step();
    do_dir("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);

    // Corner configurations: 0x80 + 0x80 on STAGES=1 and STAGES=8
    c_valid = 1'b1;
    c_a     = 8'h80;
    c_b     = 8'h80;
    c_cin   = 1'b0;
    c_sub   = 1'b0;
    c_ordy  = 1'b1;
    step();
    c_valid = 1'b0;
    c_a     = 8'h5A;
    c_b     = 8'h3C;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("s1_latency", 64'(s1_valid), 64'(i == 1));
      chk("s8_latency", 64'(s8_valid), 64'(i == 8));
      if (i == 1) begin
        chk("s1_sum", 64'(s1_sum), 64'h00);
        chk("s1_flags", {61'd0, s1_carry, s1_ovf, s1_zero}, 64'b111);
      end
    end
    chk("s8_sum", 64'(s8_sum), 64'h00);
    chk("s8_flags", {61'd0, s8_carry, s8_ovf, s8_zero}, 64'b111);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
